// File: rtl/paralelo_serial_tx.sv
// paralelo_serial_tx: byte-to-bit transmitter, MSB first, one bit per clk_32f cycle.
// After reset it sends SYNC_COUNT COM alignment bytes. After that it sends user bytes
// taken through a valid/ready handshake, and fills empty slots with IDL.
//
// Ports:
//   clk_32f     bit clock; every flop updates on the rising edge
//   reset       asynchronous reset, active low
//   data_in     byte to transmit
//   valid_in    data_in is valid
//   ready_out   holding register is empty; a byte is taken when valid_in && ready_out
//   data_out    serial bit stream, MSB first
//   byte_start  high while data_out carries bit 7 of a byte
//   active_out  the byte now on data_out was loaded in the run state
module paralelo_serial_tx #(
  parameter logic [7:0]  COM        = 8'hBC,
  parameter logic [7:0]  IDL        = 8'h7C,
  parameter int unsigned SYNC_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       byte_start,
  output logic       active_out
);

  localparam logic [3:0] SyncTarget = 4'(SYNC_COUNT);

  typedef enum logic {StSync, StRun} state_t;

  state_t     state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] sync_cnt_q, sync_cnt_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_valid_q, hold_valid_d;
  logic       byte_start_q, byte_start_d;
  logic       active_q, active_d;
  logic       boundary;

  // bit_cnt resets to 7 so that the first edge after reset is a byte boundary.
  assign boundary = (bit_cnt_q == 3'd7);

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    sync_cnt_d   = sync_cnt_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    byte_start_d = 1'b0;
    active_d     = active_q;

    if (boundary) begin
      bit_cnt_d    = 3'd0;
      byte_start_d = 1'b1;
      unique case (state_q)
        StSync: begin
          shreg_d    = COM;
          sync_cnt_d = sync_cnt_q + 4'd1;
          active_d   = 1'b0;
          if (sync_cnt_q + 4'd1 == SyncTarget) begin
            state_d = StRun;
          end
        end
        StRun: begin
          active_d = 1'b1;
          if (hold_valid_q) begin
            shreg_d      = hold_q;
            hold_valid_d = 1'b0;
          end else begin
            shreg_d = IDL;
          end
        end
      endcase
    end else begin
      shreg_d   = {shreg_q[6:0], 1'b0};
      bit_cnt_d = bit_cnt_q + 3'd1;
    end

    // Capture needs an empty hold and consume needs a full one, so they never coincide.
    // A byte captured on a boundary edge waits for the next boundary (no bypass).
    if (valid_in && !hold_valid_q) begin
      hold_d       = data_in;
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q      <= StSync;
      shreg_q      <= 8'h00;
      bit_cnt_q    <= 3'd7;
      sync_cnt_q   <= 4'd0;
      hold_q       <= 8'h00;
      hold_valid_q <= 1'b0;
      byte_start_q <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      sync_cnt_q   <= sync_cnt_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      byte_start_q <= byte_start_d;
      active_q     <= active_d;
    end
  end

  assign data_out   = shreg_q[7];
  assign byte_start = byte_start_q;
  assign active_out = active_q;
  assign ready_out  = !hold_valid_q;

endmodule
